// File: rtl/micro_seq_pkg.sv
// micro_seq_pkg: opcodes, sequencer state and microword field offsets shared
// by the sequencer, its return stack and its bus interface.
package micro_seq_pkg;

    localparam logic [3:0] OP_NEXT   = 4'd0;
    localparam logic [3:0] OP_JMP    = 4'd1;
    localparam logic [3:0] OP_JZ     = 4'd2;
    localparam logic [3:0] OP_JNZ    = 4'd3;
    localparam logic [3:0] OP_JC     = 4'd4;
    localparam logic [3:0] OP_JNC    = 4'd5;
    localparam logic [3:0] OP_CALL   = 4'd6;
    localparam logic [3:0] OP_RET    = 4'd7;
    localparam logic [3:0] OP_LDLOOP = 4'd8;
    localparam logic [3:0] OP_LOOP   = 4'd9;
    localparam logic [3:0] OP_HALT   = 4'd10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } seq_state_t;

    // Microword = {op, field, ctrl}; offsets below are measured from CTRL_W.
    localparam int OP_W      = 4;
    localparam int FIELD_W   = 8;
    localparam int FIELD_LSB = 0;
    localparam int OP_LSB    = 8;
    localparam int UW_EXTRA  = OP_W + FIELD_W;

endpackage

// File: rtl/micro_sequencer_if.sv
// micro_sequencer_if: host/ROM/datapath side of the microprogram sequencer.
// master = host + control store + datapath, slave = sequencer.
interface micro_sequencer_if
    import micro_seq_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int CTRL_W      = 17,
    parameter int STACK_DEPTH = 4
);
    localparam int LVL_W = $clog2(STACK_DEPTH + 1);

    logic                       start;
    logic [ADDR_W-1:0]          start_addr;
    logic                       abort;
    logic                       carry_flag;
    logic                       zero_flag;
    logic [CTRL_W+UW_EXTRA-1:0] uword;
    logic [ADDR_W-1:0]          uaddr;
    logic [CTRL_W-1:0]          control_bus;
    logic                       busy;
    logic                       done;
    logic                       fault;
    logic [LVL_W-1:0]           stack_level;

    modport master (
        output start, start_addr, abort, carry_flag, zero_flag, uword,
        input  uaddr, control_bus, busy, done, fault, stack_level
    );

    modport slave (
        input  start, start_addr, abort, carry_flag, zero_flag, uword,
        output uaddr, control_bus, busy, done, fault, stack_level
    );

endinterface

// File: rtl/micro_seq_stack.sv
// micro_seq_stack: small return-address LIFO built as a shift register, so the
// top of stack is always entry 0 and no pointer decode is needed.
module micro_seq_stack #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [LVL_W-1:0]            lvl;

    assign top   = mem[0];
    assign level = lvl;
    assign full  = (lvl == LVL_W'(DEPTH));
    assign empty = (lvl == '0);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            lvl <= '0;
        end else if (push && !full) begin
            mem <= {mem[DEPTH-2:0], din};
            lvl <= lvl + 1'b1;
        end else if (pop && !empty) begin
            mem <= {mem[DEPTH-1], mem[DEPTH-1:1]};
            lvl <= lvl - 1'b1;
        end
    end

endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer: microprogram sequencer with loop counter and start/done handshake.
// Define MICRO_SEQ_STACK_EN to build the return stack and enable CALL/RET.
module micro_sequencer
    import micro_seq_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int CTRL_W      = 17,
    parameter int LOOP_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    micro_sequencer_if.slave  bus
);

    localparam int LVL_W = $clog2(STACK_DEPTH + 1);

    seq_state_t         state;
    logic [ADDR_W-1:0]  pc, pc_inc, target, nxt_pc;
    logic [LOOP_W-1:0]  loop_cnt;
    logic               done_q;
    logic [OP_W-1:0]    op;
    logic [FIELD_W-1:0] field;
    logic [CTRL_W-1:0]  ctrl;
    logic               running;
    logic               op_fault, op_halt, ld_loop, dec_loop;

    assign op      = bus.uword[CTRL_W+OP_LSB +: OP_W];
    assign field   = bus.uword[CTRL_W+FIELD_LSB +: FIELD_W];
    assign ctrl    = bus.uword[CTRL_W-1:0];
    assign pc_inc  = pc + 1'b1;
    assign target  = field[ADDR_W-1:0];
    assign running = (state == RUN);

`ifdef MICRO_SEQ_STACK_EN
    logic              call_req, ret_req;
    logic              stk_full, stk_empty;
    logic [ADDR_W-1:0] stk_top;
    logic [LVL_W-1:0]  stk_level;

    // Abort wins over the executing word, so it suppresses push/pop and empties the stack.
    micro_seq_stack #(
        .WIDTH (ADDR_W),
        .DEPTH (STACK_DEPTH),
        .LVL_W (LVL_W)
    ) u_stack (
        .clock (clock),
        .reset (reset),
        .push  (running && !bus.abort && call_req),
        .pop   (running && !bus.abort && ret_req),
        .clear ((state == IDLE && bus.start) || (running && bus.abort)),
        .din   (pc_inc),
        .top   (stk_top),
        .full  (stk_full),
        .empty (stk_empty),
        .level (stk_level)
    );

    assign bus.stack_level = stk_level;
`else
    assign bus.stack_level = '0;
`endif

    always_comb begin
        nxt_pc   = pc_inc;
        op_fault = 1'b0;
        op_halt  = 1'b0;
        ld_loop  = 1'b0;
        dec_loop = 1'b0;
`ifdef MICRO_SEQ_STACK_EN
        call_req = 1'b0;
        ret_req  = 1'b0;
`endif
        case (op)
            OP_NEXT:   nxt_pc = pc_inc;
            OP_JMP:    nxt_pc = target;
            OP_JZ:     if (bus.zero_flag)   nxt_pc = target;
            OP_JNZ:    if (!bus.zero_flag)  nxt_pc = target;
            OP_JC:     if (bus.carry_flag)  nxt_pc = target;
            OP_JNC:    if (!bus.carry_flag) nxt_pc = target;
`ifdef MICRO_SEQ_STACK_EN
            OP_CALL: begin
                if (stk_full) op_fault = 1'b1;
                else begin
                    call_req = 1'b1;
                    nxt_pc   = target;
                end
            end
            OP_RET: begin
                if (stk_empty) op_fault = 1'b1;
                else begin
                    ret_req = 1'b1;
                    nxt_pc  = stk_top;
                end
            end
`endif
            OP_LDLOOP: ld_loop = 1'b1;
            OP_LOOP: begin
                if (loop_cnt != '0) begin
                    dec_loop = 1'b1;
                    nxt_pc   = target;
                end
            end
            OP_HALT:   op_halt  = 1'b1;
            default:   op_fault = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            pc       <= '0;
            loop_cnt <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state    <= RUN;
                        pc       <= bus.start_addr;
                        loop_cnt <= '0;
                    end
                end
                RUN: begin
                    // pc holds on abort, halt and fault; only a completed word advances it.
                    if (bus.abort) begin
                        state <= IDLE;
                    end else if (op_fault) begin
                        state <= FAULT;
                    end else if (op_halt) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end else begin
                        pc <= nxt_pc;
                        if (ld_loop)       loop_cnt <= field[LOOP_W-1:0];
                        else if (dec_loop) loop_cnt <= loop_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.uaddr       = pc;
    assign bus.busy        = running;
    assign bus.fault       = (state == FAULT);
    assign bus.done        = done_q;
    assign bus.control_bus = running ? ctrl : '0;

endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: directed programs plus random microcode, checked cycle by
// cycle against a queue-based behavioural model of the sequencer.
module tb_micro_sequencer;
    import micro_seq_pkg::*;

    localparam int ADDR_W      = 7;
    localparam int CTRL_W      = 17;
    localparam int LOOP_W      = 8;
    localparam int STACK_DEPTH = 4;
    localparam int UW          = CTRL_W + 12;
`ifdef MICRO_SEQ_STACK_EN
    localparam bit STACK_EN = 1'b1;
`else
    localparam bit STACK_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    micro_sequencer_if #(.ADDR_W(ADDR_W), .CTRL_W(CTRL_W), .STACK_DEPTH(STACK_DEPTH)) bus ();

    logic [UW-1:0] rom [128];
    assign bus.uword = rom[bus.uaddr];

    micro_sequencer #(
        .ADDR_W(ADDR_W), .CTRL_W(CTRL_W), .LOOP_W(LOOP_W), .STACK_DEPTH(STACK_DEPTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: 0 idle, 1 run, 2 fault; values describe the current cycle.
    int m_state, m_pc, m_loop;
    bit m_done;
    int m_stk[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [UW-1:0] mw(input int op, input int fld, input int ctrl);
        return {4'(op), 8'(fld), 17'(ctrl)};
    endfunction

    task automatic model_step(input bit st, input int sa, input bit ab, input bit z, input bit c);
        logic [UW-1:0] w;
        int op, fld, tgt, nxt;
        m_done = 1'b0;
        if (m_state == 0) begin
            if (st) begin
                m_state = 1; m_pc = sa; m_loop = 0; m_stk.delete();
            end
        end else if (m_state == 1) begin
            w   = rom[m_pc];
            op  = int'(w[CTRL_W+8 +: 4]);
            fld = int'(w[CTRL_W +: 8]);
            tgt = fld % 128;
            nxt = (m_pc + 1) % 128;
            if (ab) begin
                m_state = 0; m_stk.delete();
            end else begin
                case (op)
                    0: m_pc = nxt;
                    1: m_pc = tgt;
                    2: m_pc = z  ? tgt : nxt;
                    3: m_pc = !z ? tgt : nxt;
                    4: m_pc = c  ? tgt : nxt;
                    5: m_pc = !c ? tgt : nxt;
                    6: if (!STACK_EN || m_stk.size() == STACK_DEPTH) m_state = 2;
                       else begin m_stk.push_back(nxt); m_pc = tgt; end
                    7: if (!STACK_EN || m_stk.size() == 0) m_state = 2;
                       else m_pc = m_stk.pop_back();
                    8: begin m_loop = fld; m_pc = nxt; end
                    9: if (m_loop != 0) begin m_loop--; m_pc = tgt; end
                       else m_pc = nxt;
                    10: begin m_state = 0; m_done = 1'b1; end
                    default: m_state = 2;
                endcase
            end
        end
    endtask

    task automatic cycle(input bit st, input int sa, input bit ab, input bit z, input bit c);
        @(negedge clock);
        bus.start      = st;
        bus.start_addr = 7'(sa);
        bus.abort      = ab;
        bus.zero_flag  = z;
        bus.carry_flag = c;
        #1;
        chk("busy", bus.busy, 32'(m_state == 1));
        chk("fault", bus.fault, 32'(m_state == 2));
        chk("done", bus.done, 32'(m_done));
        chk("control_bus", bus.control_bus, (m_state == 1) ? 32'(rom[m_pc][CTRL_W-1:0]) : 32'd0);
        chk("stack_level", bus.stack_level, 32'(m_stk.size()));
        if (m_state == 1) chk("uaddr", bus.uaddr, 32'(m_pc));
        model_step(st, sa, ab, z, c);
    endtask

    task automatic rcycle();
        cycle(1'b0, 0, 1'b0, 1'($urandom), 1'($urandom));
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        @(negedge clock);
        #1;
        chk("rst_uaddr", bus.uaddr, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_fault", bus.fault, 0);
        chk("rst_control_bus", bus.control_bus, 0);
        chk("rst_stack_level", bus.stack_level, 0);
        reset = 1'b0;
        m_state = 0; m_pc = 0; m_loop = 0; m_done = 1'b0; m_stk.delete();
    endtask

    initial begin
        int cnt;
        bus.start = 1'b0; bus.start_addr = '0; bus.abort = 1'b0;
        bus.zero_flag = 1'b0; bus.carry_flag = 1'b0;
        for (int i = 0; i < 128; i++) rom[i] = mw(10, 0, 0);
        do_reset();

        // Straight line 5,6,7.
        rom[5] = mw(0, 0, 1); rom[6] = mw(0, 0, 2); rom[7] = mw(10, 0, 4);
        cycle(1, 5, 0, 0, 0);
        repeat (5) rcycle();

        // Conditional branches, both outcomes each.
        for (int op = 2; op <= 5; op++) begin
            for (int f = 0; f < 2; f++) begin
                rom[16] = mw(op, 32, 3); rom[17] = mw(10, 0, 5); rom[32] = mw(10, 0, 6);
                cycle(1, 16, 0, 0, 0);
                cycle(0, 0, 0, f[0], f[0]);
                repeat (2) rcycle();
            end
        end

        // LDLOOP 3 with a one-word self-looping body: body must appear 4 times.
        rom[48] = mw(8, 3, 1); rom[49] = mw(9, 49, 17'hAA); rom[50] = mw(10, 0, 2);
        cycle(1, 48, 0, 0, 0);
        cnt = 0;
        repeat (8) begin
            rcycle();
            if (bus.control_bus == 17'hAA) cnt++;
        end
        chk("loop_body_count", cnt, 4);

        // Nested calls to depth 4 then unwinding.
        rom[64] = mw(6, 72, 8'h10); rom[65] = mw(10, 0, 8'h11);
        rom[72] = mw(6, 80, 8'h12); rom[73] = mw(7, 0, 8'h13);
        rom[80] = mw(6, 88, 8'h14); rom[81] = mw(7, 0, 8'h15);
        rom[88] = mw(6, 96, 8'h16); rom[89] = mw(7, 0, 8'h17);
        rom[96] = mw(7, 0, 8'h18);
        cycle(1, 64, 0, 0, 0);
        repeat (12) rcycle();

        // Fifth call overflows; start/abort ignored while faulted.
        rom[112] = mw(6, 112, 8'h21);
        cycle(1, 112, 0, 0, 0);
        repeat (7) rcycle();
        cycle(1, 5, 1, 0, 0);
        cycle(1, 5, 0, 0, 0);
        do_reset();

        // RET on an empty stack.
        rom[114] = mw(7, 0, 8'h22);
        cycle(1, 114, 0, 0, 0);
        repeat (3) rcycle();
        do_reset();

        // Abort on the HALT cycle, then an immediate restart; then start+abort in IDLE.
        rom[8] = mw(0, 0, 8'h31); rom[9] = mw(10, 0, 8'h32);
        cycle(1, 8, 0, 0, 0);
        rcycle();
        cycle(0, 0, 1, 0, 0);
        cycle(1, 5, 0, 0, 0);
        repeat (4) rcycle();
        cycle(1, 5, 1, 0, 0);
        repeat (4) rcycle();

        // Address wrap at 0x7F.
        rom[127] = mw(0, 0, 8'h33); rom[0] = mw(10, 0, 8'h44);
        cycle(1, 127, 0, 0, 0);
        repeat (3) rcycle();

        // Reserved opcodes fault; reset clears.
        for (int op = 11; op <= 15; op++) begin
            rom[100] = mw(op, 0, 7);
            cycle(1, 100, 0, 0, 0);
            repeat (2) rcycle();
            do_reset();
        end

        // Random microcode.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 128; i++)
                rom[i] = mw(($urandom_range(0, 39) == 0) ? $urandom_range(11, 15) : $urandom_range(0, 10),
                            $urandom_range(0, 255), int'($urandom & 32'h1FFFF));
            repeat (200) begin
                cycle(($urandom_range(0, 3) == 0), $urandom_range(0, 127),
                      ($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom));
                if (m_state == 2 && $urandom_range(0, 3) == 0) do_reset();
            end
            do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
